// File: rtl/reg_writeback_pkg.sv
// Shared types and helpers for the register writeback path.
package reg_writeback_pkg;

    localparam int NREGS = 16;
    localparam int WIDTH = 64;
    localparam int RID_W = 4;

    typedef struct packed {
        logic             we0;
        logic [RID_W-1:0] dst0;
        logic [WIDTH-1:0] val0;
        logic             we1;
        logic [RID_W-1:0] dst1;
        logic [WIDTH-1:0] val1;
        logic             halt;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_HI  = 2'd1,
        HALTED = 2'd2
    } wb_state_t;

    function automatic logic [WIDTH-1:0] get_64(input logic [NREGS*WIDTH-1:0] flat,
                                                input logic [RID_W-1:0] id);
        get_64 = flat[id*WIDTH +: WIDTH];
    endfunction

    function automatic logic [NREGS-1:0] onehot(input logic [RID_W-1:0] id);
        onehot = {{(NREGS-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// In-order result queue with wrapping pointers and an age-ordered view of all entries.
module wb_fifo
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push_i,
    input  wb_entry_t                     push_data_i,
    input  logic                          pop_i,
    output wb_entry_t                     head_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output wb_entry_t [DEPTH-1:0]         age_entries_o,
    output logic [DEPTH-1:0]              age_valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_q <= count_q;
            endcase
        end
    end

    // Entries re-indexed by age: slot 0 is the head, higher slots are younger.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            age_entries_o[k] = mem_q[rd_ptr_q + PTR_W'(k)];
            age_valid_o[k]   = (CNT_W'(k) < count_q);
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Commits queued ALU results into the 16x64 register file, one write per cycle.
// Optional macro WB_BYPASS_EN forwards the youngest queued value to the read ports.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_we0,
    input  logic [RID_W-1:0]       in_dst0,
    input  logic [WIDTH-1:0]       in_val0,
    input  logic                   in_we1,
    input  logic [RID_W-1:0]       in_dst1,
    input  logic [WIDTH-1:0]       in_val1,
    input  logic                   in_halt,
    input  logic [RID_W-1:0]       rd_id_a,
    output logic [WIDTH-1:0]       rd_val_a,
    input  logic [RID_W-1:0]       rd_id_b,
    output logic [WIDTH-1:0]       rd_val_b,
    output logic [NREGS-1:0]       busy_mask,
    output logic [NREGS*WIDTH-1:0] reg_file_flat,
    output logic                   empty,
    output logic                   halted
);

    wb_state_t                        state_q;
    wb_state_t                        state_d;
    logic [NREGS-1:0][WIDTH-1:0]      rf_q;
    logic                             halted_q;
    wb_entry_t                        push_data_s;
    wb_entry_t                        head_s;
    wb_entry_t [DEPTH-1:0]            age_entries_s;
    logic [DEPTH-1:0]                 age_valid_s;
    logic                             fifo_full_s;
    logic                             fifo_empty_s;
    logic [$clog2(DEPTH):0]           fifo_count_s;
    logic                             pop_s;
    logic                             wr_en_s;
    logic [RID_W-1:0]                 wr_id_s;
    logic [WIDTH-1:0]                 wr_val_s;
    logic [NREGS-1:0]                 busy_s;

    assign push_data_s = '{we0: in_we0, dst0: in_dst0, val0: in_val0,
                           we1: in_we1, dst1: in_dst1, val1: in_val1, halt: in_halt};
    // A full queue refuses even when the head pops this cycle.
    assign in_ready      = !fifo_full_s && !halted_q;
    assign halted        = halted_q;
    assign empty         = fifo_empty_s && (state_q == IDLE);
    assign reg_file_flat = rf_q;
    assign busy_mask     = busy_s;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk           (clk),
        .reset_n       (reset_n),
        .push_i        (in_valid && in_ready),
        .push_data_i   (push_data_s),
        .pop_i         (pop_s),
        .head_o        (head_s),
        .full_o        (fifo_full_s),
        .empty_o       (fifo_empty_s),
        .count_o       (fifo_count_s),
        .age_entries_o (age_entries_s),
        .age_valid_o   (age_valid_s)
    );

    // Write-port scheduling: dst0 in IDLE, dst1 in WR_HI, pop on the last write.
    always_comb begin
        state_d  = state_q;
        pop_s    = 1'b0;
        wr_en_s  = 1'b0;
        wr_id_s  = {RID_W{1'b0}};
        wr_val_s = {WIDTH{1'b0}};
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    wr_en_s  = head_s.we0;
                    wr_id_s  = head_s.dst0;
                    wr_val_s = head_s.val0;
                    if (head_s.we1) begin
                        state_d = WR_HI;
                    end else begin
                        pop_s   = 1'b1;
                        state_d = head_s.halt ? HALTED : IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WR_HI: begin
                wr_en_s  = 1'b1;
                wr_id_s  = head_s.dst1;
                wr_val_s = head_s.val1;
                pop_s    = 1'b1;
                state_d  = head_s.halt ? HALTED : IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, register file and halt flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rf_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALTED);
            if (wr_en_s) begin
                rf_q[wr_id_s] <= wr_val_s;
            end
        end
    end

    // Pending-write mask covers every queued entry, head included until it pops.
    always_comb begin
        busy_s = {NREGS{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            busy_s = busy_s
                   | ((age_valid_s[k] && age_entries_s[k].we0) ? onehot(age_entries_s[k].dst0) : {NREGS{1'b0}})
                   | ((age_valid_s[k] && age_entries_s[k].we1) ? onehot(age_entries_s[k].dst1) : {NREGS{1'b0}});
        end
    end

`ifdef WB_BYPASS_EN
    // Oldest-to-youngest scan so the youngest matching write wins; dst1 overrides dst0.
    always_comb begin
        rd_val_a = get_64(rf_q, rd_id_a);
        rd_val_b = get_64(rf_q, rd_id_b);
        for (int k = 0; k < DEPTH; k++) begin
            rd_val_a = (age_valid_s[k] && age_entries_s[k].we0 && age_entries_s[k].dst0 == rd_id_a)
                     ? age_entries_s[k].val0 : rd_val_a;
            rd_val_a = (age_valid_s[k] && age_entries_s[k].we1 && age_entries_s[k].dst1 == rd_id_a)
                     ? age_entries_s[k].val1 : rd_val_a;
            rd_val_b = (age_valid_s[k] && age_entries_s[k].we0 && age_entries_s[k].dst0 == rd_id_b)
                     ? age_entries_s[k].val0 : rd_val_b;
            rd_val_b = (age_valid_s[k] && age_entries_s[k].we1 && age_entries_s[k].dst1 == rd_id_b)
                     ? age_entries_s[k].val1 : rd_val_b;
        end
    end
`else
    assign rd_val_a = get_64(rf_q, rd_id_a);
    assign rd_val_b = get_64(rf_q, rd_id_b);
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback against a queue-based reference model.
module tb_reg_writeback;
    import reg_writeback_pkg::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_we0;
    logic [3:0]             in_dst0;
    logic [63:0]            in_val0;
    logic                   in_we1;
    logic [3:0]             in_dst1;
    logic [63:0]            in_val1;
    logic                   in_halt;
    logic [3:0]             rd_id_a;
    logic [63:0]            rd_val_a;
    logic [3:0]             rd_id_b;
    logic [63:0]            rd_val_b;
    logic [15:0]            busy_mask;
    logic [1023:0]          reg_file_flat;
    logic                   empty;
    logic                   halted;

    int errors = 0;
    int checks = 0;

    wb_entry_t   mq[$];
    logic [63:0] mrf[16];
    bit          mhi;
    bit          mhalt;

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_we0(in_we0), .in_dst0(in_dst0), .in_val0(in_val0),
        .in_we1(in_we1), .in_dst1(in_dst1), .in_val1(in_val1), .in_halt(in_halt),
        .rd_id_a(rd_id_a), .rd_val_a(rd_val_a), .rd_id_b(rd_id_b), .rd_val_b(rd_val_b),
        .busy_mask(busy_mask), .reg_file_flat(reg_file_flat), .empty(empty), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return (mq.size() < DEPTH) && !mhalt;
    endfunction

    function automatic bit m_empty();
        return (mq.size() == 0) && !mhalt;
    endfunction

    function automatic logic [15:0] m_busy();
        logic [15:0] b = 16'h0000;
        foreach (mq[k]) begin
            if (mq[k].we0) b[mq[k].dst0] = 1'b1;
            if (mq[k].we1) b[mq[k].dst1] = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [1023:0] m_flat();
        logic [1023:0] f;
        for (int r = 0; r < 16; r++) f[r*64 +: 64] = mrf[r];
        return f;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] id);
        logic [63:0] v = mrf[id];
`ifdef WB_BYPASS_EN
        foreach (mq[k]) begin
            if (mq[k].we0 && mq[k].dst0 == id) v = mq[k].val0;
            if (mq[k].we1 && mq[k].dst1 == id) v = mq[k].val1;
        end
`endif
        return v;
    endfunction

    function automatic wb_entry_t mk(input bit w0, input logic [3:0] d0, input logic [63:0] v0,
                                     input bit w1, input logic [3:0] d1, input logic [63:0] v1,
                                     input bit h);
        wb_entry_t e;
        e.we0 = w0; e.dst0 = d0; e.val0 = v0;
        e.we1 = w1; e.dst1 = d1; e.val1 = v1;
        e.halt = h;
        return e;
    endfunction

    // One clock edge of the reference: retire per the write-port rules, then accept.
    task automatic m_edge(input bit push, input wb_entry_t e);
        bit acc;
        wb_entry_t h;
        acc = push && m_ready();
        if (!mhalt && mq.size() > 0) begin
            h = mq[0];
            if (!mhi) begin
                if (h.we0) mrf[h.dst0] = h.val0;
                if (h.we1) mhi = 1'b1;
                else begin
                    void'(mq.pop_front());
                    if (h.halt) mhalt = 1'b1;
                end
            end else begin
                mrf[h.dst1] = h.val1;
                mhi = 1'b0;
                void'(mq.pop_front());
                if (h.halt) mhalt = 1'b1;
            end
        end
        if (acc) mq.push_back(e);
    endtask

    task automatic tick(input bit v, input wb_entry_t e);
        in_valid = v;
        in_we0 = e.we0; in_dst0 = e.dst0; in_val0 = e.val0;
        in_we1 = e.we1; in_dst1 = e.dst1; in_val1 = e.val1;
        in_halt = e.halt;
        @(posedge clk);
        m_edge(v, e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        mhi = 1'b0;
        mhalt = 1'b0;
        for (int r = 0; r < 16; r++) mrf[r] = 64'h0;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
        checks++; if (busy_mask !== 16'h0000) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy_mask); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", in_ready); end
        checks++; if (reg_file_flat !== 1024'h0) begin errors++; $display("FAIL reset_file: got %0h expected 0", reg_file_flat); end
    endtask

    task automatic test_single();
        rd_id_a = 4'd3;
        tick(1'b1, mk(1'b1, 4'd3, 64'h55, 1'b0, 4'd0, 64'h0, 1'b0));
        checks++; if (busy_mask !== 16'h0008) begin errors++; $display("FAIL single_busy_pending: got %0h expected 8", busy_mask); end
        checks++; if (rd_val_a !== m_read(4'd3)) begin errors++; $display("FAIL single_read_pending: got %0h expected %0h", rd_val_a, m_read(4'd3)); end
        tick(1'b0, mk(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 1'b0));
        checks++; if (reg_file_flat[3*64 +: 64] !== 64'h55) begin errors++; $display("FAIL single_commit: got %0h expected 55", reg_file_flat[3*64 +: 64]); end
        checks++; if (busy_mask !== 16'h0000) begin errors++; $display("FAIL single_busy_clear: got %0h expected 0", busy_mask); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_imul();
        tick(1'b1, mk(1'b1, 4'd0, 64'h1, 1'b1, 4'd2, 64'h2, 1'b0));
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL imul_ready_e0: got %0b expected 1", in_ready); end
        tick(1'b0, mk(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 1'b0));
        checks++; if (reg_file_flat[0 +: 64] !== 64'h1) begin errors++; $display("FAIL imul_rax: got %0h expected 1", reg_file_flat[0 +: 64]); end
        checks++; if (reg_file_flat[2*64 +: 64] !== 64'h0) begin errors++; $display("FAIL imul_rdx_early: got %0h expected 0", reg_file_flat[2*64 +: 64]); end
        checks++; if (busy_mask !== 16'h0005) begin errors++; $display("FAIL imul_busy: got %0h expected 5", busy_mask); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL imul_ready_e1: got %0b expected 1", in_ready); end
        tick(1'b0, mk(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 1'b0));
        checks++; if (reg_file_flat[2*64 +: 64] !== 64'h2) begin errors++; $display("FAIL imul_rdx: got %0h expected 2", reg_file_flat[2*64 +: 64]); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL imul_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_back_to_back();
        wb_entry_t ents[8];
        int idx = 0;
        int cyc = 0;
        bit acc;
        bit saw_full = 1'b0;
        for (int i = 0; i < 8; i++)
            ents[i] = mk(1'b1, 4'($urandom_range(0, 15)), {$urandom, $urandom},
                         1'b1, 4'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b0);
        while (idx < 8 && cyc < 200) begin
            acc = m_ready();
            tick(1'b1, ents[idx]);
            if (acc) idx++;
            cyc++;
            checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL b2b_ready: got %0b expected %0b", in_ready, m_ready()); end
            checks++; if (reg_file_flat !== m_flat()) begin errors++; $display("FAIL b2b_file: got %0h expected %0h", reg_file_flat, m_flat()); end
            if (in_ready === 1'b0 && mq.size() == DEPTH) saw_full = 1'b1;
        end
        checks++; if (idx != 8) begin errors++; $display("FAIL b2b_accept_timeout: got %0d expected 8", idx); end
        checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL b2b_full_stall: got %0b expected 1", saw_full); end
        cyc = 0;
        while (empty !== 1'b1 && cyc < 50) begin
            tick(1'b0, mk(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 1'b0));
            cyc++;
            checks++; if (reg_file_flat !== m_flat()) begin errors++; $display("FAIL b2b_drain_file: got %0h expected %0h", reg_file_flat, m_flat()); end
        end
        checks++; if (empty !== 1'b1 || mq.size() != 0) begin errors++; $display("FAIL b2b_drain_timeout: got empty=%0b expected 1", empty); end
    endtask

    task automatic test_same_dst();
        tick(1'b1, mk(1'b1, 4'd7, 64'hA, 1'b1, 4'd7, 64'hB, 1'b0));
        repeat (2) tick(1'b0, mk(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 1'b0));
        checks++; if (reg_file_flat[7*64 +: 64] !== 64'hB) begin errors++; $display("FAIL same_dst: got %0h expected b", reg_file_flat[7*64 +: 64]); end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_a;
        do_reset();
        rd_id_a = 4'd4;
        rd_id_b = 4'd9;
        tick(1'b1, mk(1'b1, 4'd8, 64'h3, 1'b1, 4'd9, 64'h4, 1'b0));
        tick(1'b1, mk(1'b1, 4'd4, 64'h10, 1'b0, 4'd0, 64'h0, 1'b0));
        tick(1'b1, mk(1'b1, 4'd4, 64'h20, 1'b0, 4'd0, 64'h0, 1'b0));
`ifdef WB_BYPASS_EN
        exp_a = 64'h20;
`else
        exp_a = 64'h0;
`endif
        checks++; if (rd_val_a !== exp_a) begin errors++; $display("FAIL bypass_read_a: got %0h expected %0h", rd_val_a, exp_a); end
        checks++; if (rd_val_b !== 64'h4) begin errors++; $display("FAIL bypass_read_b: got %0h expected 4", rd_val_b); end
        checks++; if (busy_mask !== 16'h0010) begin errors++; $display("FAIL bypass_busy: got %0h expected 10", busy_mask); end
        repeat (2) tick(1'b0, mk(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 1'b0));
        checks++; if (rd_val_a !== 64'h20) begin errors++; $display("FAIL bypass_final: got %0h expected 20", rd_val_a); end
    endtask

    task automatic test_halt();
        logic [63:0] r1;
        r1 = mrf[1];
        tick(1'b1, mk(1'b0, 4'd0, 64'h0, 1'b0, 4'd0, 64'h0, 1'b1));
        tick(1'b1, mk(1'b1, 4'd1, 64'h77, 1'b0, 4'd0, 64'h0, 1'b0));
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %0b expected 1", halted); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_ready: got %0b expected 0", in_ready); end
        repeat (3) tick(1'b1, mk(1'b1, 4'd1, 64'h99, 1'b0, 4'd0, 64'h0, 1'b0));
        checks++; if (reg_file_flat[64 +: 64] !== r1) begin errors++; $display("FAIL halt_reg1: got %0h expected %0h", reg_file_flat[64 +: 64], r1); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL halt_empty: got %0b expected 0", empty); end
        do_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset_flag: got %0b expected 0", halted); end
        checks++; if (reg_file_flat !== 1024'h0) begin errors++; $display("FAIL halt_reset_file: got %0h expected 0", reg_file_flat); end
        checks++; if (busy_mask !== 16'h0000 || empty !== 1'b1) begin errors++; $display("FAIL halt_reset_queue: got busy=%0h empty=%0b expected 0 1", busy_mask, empty); end
    endtask

    task automatic test_random();
        int halt_cycles = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rd_id_a = 4'($urandom_range(0, 15));
            rd_id_b = 4'($urandom_range(0, 15));
            tick(1'($urandom_range(0, 3) != 0),
                 mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                    1'($urandom_range(0, 39) == 0)));
            checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", c, in_ready, m_ready()); end
            checks++; if (empty !== m_empty()) begin errors++; $display("FAIL rnd_empty c%0d: got %0b expected %0b", c, empty, m_empty()); end
            checks++; if (halted !== mhalt) begin errors++; $display("FAIL rnd_halted c%0d: got %0b expected %0b", c, halted, mhalt); end
            checks++; if (busy_mask !== m_busy()) begin errors++; $display("FAIL rnd_busy c%0d: got %0h expected %0h", c, busy_mask, m_busy()); end
            checks++; if (reg_file_flat !== m_flat()) begin errors++; $display("FAIL rnd_file c%0d: got %0h expected %0h", c, reg_file_flat, m_flat()); end
            checks++; if (rd_val_a !== m_read(rd_id_a)) begin errors++; $display("FAIL rnd_read_a c%0d: got %0h expected %0h", c, rd_val_a, m_read(rd_id_a)); end
            checks++; if (rd_val_b !== m_read(rd_id_b)) begin errors++; $display("FAIL rnd_read_b c%0d: got %0h expected %0h", c, rd_val_b, m_read(rd_id_b)); end
            halt_cycles = mhalt ? halt_cycles + 1 : 0;
            if (halt_cycles > 3 || $urandom_range(0, 99) == 0) begin
                do_reset();
                halt_cycles = 0;
                checks++; if (empty !== 1'b1 || busy_mask !== 16'h0000) begin errors++; $display("FAIL rnd_reset c%0d: got empty=%0b busy=%0h expected 1 0", c, empty, busy_mask); end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_we0 = 1'b0; in_dst0 = 4'd0; in_val0 = 64'h0;
        in_we1 = 1'b0; in_dst1 = 4'd0; in_val1 = 64'h0;
        in_halt = 1'b0;
        rd_id_a = 4'd0;
        rd_id_b = 4'd0;
        test_reset();
        test_single();
        test_imul();
        test_same_dst();
        test_back_to_back();
        test_bypass();
        test_halt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
